// File: rtl/oled_pkg.sv
// Shared geometry and FSM state encoding for the OLED row scheduler.
package oled_pkg;
  localparam int OLED_ROWS = 4;
  localparam int OLED_COLS = 16;
  localparam int CHAR_W    = 8;
  localparam int ADDR_W    = 9;
  localparam int ROW_W     = OLED_COLS * CHAR_W;
  localparam int IDX_W     = $clog2(OLED_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WSTART,
    S_WGAP,
    S_WWAIT,
    S_UPD,
    S_UGAP,
    S_UWAIT
  } sched_state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 3 -> 0.
module rr_arbiter4
  import oled_pkg::*;
(
  input  logic [OLED_ROWS-1:0] req,
  input  logic [1:0]           ptr,
  output logic [1:0]           grant_idx,
  output logic                 grant_valid
);

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    for (int i = OLED_ROWS - 1; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        grant_valid = 1'b1;
        grant_idx   = ptr + 2'(i);
      end
    end
  end

endmodule

// File: rtl/oled_row_scheduler.sv
// Shares the OLEDCtrl write/update ports between four row producers; streams one
// granted row at a time and issues coalesced, rate-limited display updates.
module oled_row_scheduler
  import oled_pkg::*;
#(
  parameter int MIN_UPDATE_CYCLES = 1000000,
  parameter int MAX_COALESCE      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          oled_on,
  input  logic [OLED_ROWS-1:0]          req,
  input  logic [OLED_ROWS*ROW_W-1:0]    row_data,
  output logic [OLED_ROWS-1:0]          ack,
  output logic                          write_start,
  output logic [ADDR_W-1:0]             write_base_addr,
  output logic [CHAR_W-1:0]             write_ascii_data,
  input  logic                          write_ready,
  output logic                          update_start,
  output logic                          update_clear,
  input  logic                          update_ready,
  output logic                          busy
);

  localparam int                CNT_W    = $clog2(MIN_UPDATE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_UPDATE_CYCLES);
  localparam logic [2:0]        MAX_ROWS = 3'(MAX_COALESCE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OLED_COLS - 1);

  sched_state_t      state;
  logic [1:0]        rr_ptr;
  logic [1:0]        row_idx;
  logic [IDX_W-1:0]  char_idx;
  logic [2:0]        rows_done;
  logic [ROW_W-1:0]  row_latch;
  logic [CNT_W-1:0]  since_upd;
  logic [1:0]        grant_idx;
  logic              grant_valid;

  rr_arbiter4 u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign update_clear = 1'b0;
  assign busy         = (state != S_IDLE);

  // Pulses default low each cycle; since_upd saturates so a long idle display updates at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      row_idx          <= '0;
      char_idx         <= '0;
      rows_done        <= '0;
      row_latch        <= '0;
      since_upd        <= MIN_CNT;
      ack              <= '0;
      write_start      <= 1'b0;
      write_base_addr  <= '0;
      write_ascii_data <= '0;
      update_start     <= 1'b0;
    end else begin
      ack          <= '0;
      write_start  <= 1'b0;
      update_start <= 1'b0;
      if (since_upd != MIN_CNT) since_upd <= since_upd + 1'b1;

      case (state)
        S_IDLE: begin
          if (oled_on && (|req))              state <= S_GRANT;
          else if (oled_on && rows_done != 0) state <= S_UPD;
        end
        S_GRANT: begin
          if (grant_valid) begin
            row_latch      <= row_data[grant_idx*ROW_W +: ROW_W];
            row_idx        <= grant_idx;
            ack[grant_idx] <= 1'b1;
            rr_ptr         <= grant_idx + 2'd1;
            char_idx       <= '0;
            state          <= S_WSTART;
          end else if (rows_done != 0) begin
            state <= S_UPD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WSTART: begin
          if (write_ready) begin
            write_start      <= 1'b1;
            write_base_addr  <= {row_idx, char_idx, 3'b000};
            write_ascii_data <= row_latch[{~char_idx, 3'b111} -: CHAR_W];
            state            <= S_WGAP;
          end
        end
        // OLEDCtrl drops write_ready a cycle late, so it is not trusted here.
        S_WGAP: state <= S_WWAIT;
        S_WWAIT: begin
          if (write_ready) begin
            if (char_idx == LAST_IDX) begin
              rows_done <= rows_done + 3'd1;
              if ((rows_done + 3'd1) == MAX_ROWS || !(|req)) state <= S_UPD;
              else                                           state <= S_GRANT;
            end else begin
              char_idx <= char_idx + 1'b1;
              state    <= S_WSTART;
            end
          end
        end
        S_UPD: begin
          if (update_ready && since_upd == MIN_CNT) begin
            update_start <= 1'b1;
            rows_done    <= '0;
            since_upd    <= '0;
            state        <= S_UGAP;
          end
        end
        S_UGAP: state <= S_UWAIT;
        S_UWAIT: begin
          if (update_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_row_scheduler.sv
// Scoreboard bench for oled_row_scheduler with a simple OLEDCtrl model.
module tb_oled_row_scheduler;
  localparam int MIN_UPD = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         oled_on = 1'b0;
  logic [3:0]   req = '0;
  logic [511:0] row_data = '0;
  logic         write_ready = 1'b1;
  logic         update_ready = 1'b1;
  logic         stall = 1'b0;
  logic [3:0]   ack;
  logic         write_start;
  logic [8:0]   write_base_addr;
  logic [7:0]   write_ascii_data;
  logic         update_start;
  logic         update_clear;
  logic         busy;

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_ack[$];
  int  exp_upd[$];

  int checks = 0;
  int passes = 0;
  int viol = 0;
  int ack_seen = 0;
  int ws_seen = 0;

  string hello = "HELLO WORLD     ";
  string row1s = "ABCDEFGHIJKLMNOP";
  string row2s = "abcdefghijklmnop";
  string row3s = "0123456789abcdef";
  string stls  = "0123456789ABCDEF";

  always #5 clk = ~clk;

  oled_row_scheduler #(.MIN_UPDATE_CYCLES(MIN_UPD), .MAX_COALESCE(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .oled_on          (oled_on),
    .req              (req),
    .row_data         (row_data),
    .ack              (ack),
    .write_start      (write_start),
    .write_base_addr  (write_base_addr),
    .write_ascii_data (write_ascii_data),
    .write_ready      (write_ready),
    .update_start     (update_start),
    .update_clear     (update_clear),
    .update_ready     (update_ready),
    .busy             (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
  endtask

  task automatic reportFail(input string name, input logic [31:0] actual);
    checks++;
    $display("[TB] FAIL %s: actual 0x%0h required nothing/completion", name, actual);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    @(negedge clk);
    req = r;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setRow(input int r, input string s);
    for (int c = 0; c < 16; c++) row_data[128*r + 8*(15-c) +: 8] = s[c];
  endtask

  task automatic pushRow(input int r, input string s, input int n);
    wr_t w;
    for (int c = 0; c < n; c++) begin
      w.addr = 9'(r*128 + c*8);
      w.data = s[c];
      exp_wr.push_back(w);
    end
  endtask

  task automatic serveRequests(input int budget, input string name);
    int  n = 0;
    bit  done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      req = req & ~ack;
      if (req == 0 && !busy && exp_upd.size() == 0) done = 1;
    end
    if (!done) reportFail({name, "_timeout"}, n);
  endtask

  task automatic waitWrite(input logic [8:0] addr, input bit clear_req, input string name);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 3000) begin
      @(negedge clk);
      n++;
      if (clear_req) req = req & ~ack;
      if (write_start && write_base_addr == addr) hit = 1;
    end
    if (!hit) reportFail({name, "_timeout"}, n);
  endtask

  // OLEDCtrl model: write port busy 4 cycles, update port busy 6 cycles.
  initial begin
    int wr_cnt = 0;
    int up_cnt = 0;
    forever begin
      @(negedge clk);
      if (write_start) begin write_ready = 1'b0; wr_cnt = 3; end
      else if (wr_cnt > 0) wr_cnt--;
      else if (!stall) write_ready = 1'b1;
      if (update_start) begin update_ready = 1'b0; up_cnt = 5; end
      else if (up_cnt > 0) up_cnt--;
      else update_ready = 1'b1;
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT presents an ack, write or update.
  initial begin
    int cycle = 0;
    int last_upd = 0;
    int gap;
    bit have_upd = 0;
    bit prev_ws = 0;
    bit prev_us = 0;
    int writes_since = 0;
    wr_t w;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        writes_since = 0;
        have_upd = 0;
        prev_ws = 0;
        prev_us = 0;
      end else begin
        if ((write_start && update_start) || (write_start && prev_ws) || (update_start && prev_us)) viol++;
        if (ack != 0) begin
          ack_seen++;
          if (exp_ack.size() == 0) reportFail("unexpected_ack", ack);
          else checkOutput("ack_onehot", ack, 4'b0001 << exp_ack.pop_front());
        end
        if (write_start) begin
          ws_seen++;
          writes_since++;
          if (exp_wr.size() == 0) reportFail("unexpected_write", write_base_addr);
          else begin
            w = exp_wr.pop_front();
            checkOutput("write_addr", write_base_addr, w.addr);
            checkOutput("write_data", write_ascii_data, w.data);
          end
        end
        if (update_start) begin
          if (exp_upd.size() == 0) reportFail("unexpected_update", writes_since);
          else checkOutput("writes_before_update", writes_since, exp_upd.pop_front());
          writes_since = 0;
          if (have_upd) begin
            gap = cycle - last_upd;
            checkOutput("update_gap_min", (gap >= MIN_UPD) ? MIN_UPD : gap, MIN_UPD);
          end
          have_upd = 1;
          last_upd = cycle;
        end
        prev_ws = write_start;
        prev_us = update_start;
      end
    end
  end

  initial begin
    int a0, w0, mism, lat;

    applyReset();
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_write_start", write_start, 0);
    checkOutput("reset_update_start", update_start, 0);
    checkOutput("reset_addr", write_base_addr, 0);
    checkOutput("reset_data", write_ascii_data, 0);
    checkOutput("reset_update_clear", update_clear, 0);
    checkOutput("reset_busy", busy, 0);

    // Single row "HELLO WORLD", then two separate rows to exercise the rate limit.
    setRow(0, hello);
    setRow(1, row1s);
    setRow(2, row2s);
    setRow(3, row3s);
    exp_ack.push_back(0); pushRow(0, hello, 16); exp_upd.push_back(16);
    oled_on = 1'b1;
    applyStimulus(4'b0001);
    serveRequests(3000, "hello");

    exp_ack.push_back(1); pushRow(1, row1s, 16); exp_upd.push_back(16);
    applyStimulus(4'b0010);
    serveRequests(3000, "row1");
    exp_ack.push_back(3); pushRow(3, row3s, 16); exp_upd.push_back(16);
    applyStimulus(4'b1000);
    serveRequests(3000, "row3");

    // All four rows held from reset coalesce into one update.
    req = 4'b1111;
    for (int r = 0; r < 4; r++) exp_ack.push_back(r);
    pushRow(0, hello, 16); pushRow(1, row1s, 16); pushRow(2, row2s, 16); pushRow(3, row3s, 16);
    exp_upd.push_back(64);
    applyReset();
    serveRequests(10000, "coalesce");

    // Reset in the middle of row 2; the held request is re-acked from char 0.
    req = 4'b0000;
    applyReset();
    exp_ack.push_back(2); pushRow(2, row2s, 8);
    applyStimulus(4'b0100);
    waitWrite(9'(2*128 + 7*8), 1'b0, "mid_row");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ack", ack, 0);
    checkOutput("midrst_write_start", write_start, 0);
    checkOutput("midrst_update_start", update_start, 0);
    checkOutput("midrst_addr", write_base_addr, 0);
    checkOutput("midrst_data", write_ascii_data, 0);
    checkOutput("midrst_busy", busy, 0);
    exp_ack.push_back(2); pushRow(2, row2s, 16); exp_upd.push_back(16);
    rst = 1'b0;
    serveRequests(3000, "rerow2");

    // Display off: requests wait; turning it on grants after two cycles.
    oled_on = 1'b0;
    applyStimulus(4'b0100);
    a0 = ack_seen;
    w0 = ws_seen;
    repeat (1000) @(negedge clk);
    checkOutput("off_acks", ack_seen - a0, 0);
    checkOutput("off_writes", ws_seen - w0, 0);
    exp_ack.push_back(2); pushRow(2, row2s, 16); exp_upd.push_back(16);
    oled_on = 1'b1;
    lat = 0;
    while (lat < 10 && ack == 0) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("on_ack_latency", lat, 2);
    req = req & ~ack;
    serveRequests(3000, "on_row2");

    // write_ready held low mid-row: outputs hold, nothing new is issued.
    setRow(0, stls);
    exp_ack.push_back(0); pushRow(0, stls, 16); exp_upd.push_back(16);
    applyStimulus(4'b0001);
    waitWrite(9'd40, 1'b1, "stall_char5");
    stall = 1'b1;
    a0 = ack_seen;
    w0 = ws_seen;
    mism = 0;
    repeat (500) begin
      @(negedge clk);
      if (write_base_addr !== 9'd40 || write_ascii_data !== stls[5]) mism++;
    end
    checkOutput("stall_hold_mismatches", mism, 0);
    checkOutput("stall_writes", ws_seen - w0, 0);
    checkOutput("stall_acks", ack_seen - a0, 0);
    stall = 1'b0;
    serveRequests(3000, "stall_row");

    repeat (5) @(negedge clk);
    checkOutput("leftover_expected", exp_wr.size() + exp_ack.size() + exp_upd.size(), 0);
    checkOutput("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
